// File: rtl/pwm_capture_if.sv
// Measurement bundle between a PWM source/observer (master) and pwm_capture (slave).
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 32
);
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic [6:0]       duty_pct;
    logic             duty_valid;

    modport master (
        output pwm_in,
        input  period, high_time, meas_valid, stuck_high, stuck_low, duty_pct, duty_valid
    );

    modport slave (
        input  pwm_in,
        output period, high_time, meas_valid, stuck_high, stuck_low, duty_pct, duty_valid
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM period/high-time capture with stuck-line detection.
// Optional duty-cycle divider enabled by defining PWM_CAPTURE_DUTY_EN.
module pwm_capture #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1000
) (
    input logic           clk,
    input logic           reset,
    pwm_capture_if.slave  bus_io
);
    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             meas_valid_q;
    logic             stuck_high_q;
    logic             stuck_low_q;
    logic             timeout_hit;
    state_e           state_q;

    assign rise        = s2_q & ~s3_q;
    assign fall        = ~s2_q & s3_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1)) && !rise && !fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q <= bus_io.pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            // Counter runs from the last rise; it saturates so IDLE never wraps it.
            if (rise) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (rise || fall) begin
                stuck_high_q <= 1'b0;
                stuck_low_q  <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (rise) state_q <= StHigh;
                end
                StHigh: begin
                    if (fall) begin
                        hcnt_q  <= cnt_q + CNT_W'(1);
                        state_q <= StLow;
                    end else if (timeout_hit) begin
                        state_q      <= StIdle;
                        stuck_high_q <= s2_q;
                        stuck_low_q  <= ~s2_q;
                    end
                end
                StLow: begin
                    if (rise) begin
                        period_q     <= cnt_q + CNT_W'(1);
                        high_time_q  <= hcnt_q;
                        meas_valid_q <= 1'b1;
                        state_q      <= StHigh;
                    end else if (timeout_hit) begin
                        state_q      <= StIdle;
                        stuck_high_q <= s2_q;
                        stuck_low_q  <= ~s2_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.period     = period_q;
    assign bus_io.high_time  = high_time_q;
    assign bus_io.meas_valid = meas_valid_q;
    assign bus_io.stuck_high = stuck_high_q;
    assign bus_io.stuck_low  = stuck_low_q;

`ifdef PWM_CAPTURE_DUTY_EN
    localparam int unsigned DW = CNT_W + 7;

    logic [DW-1:0] rem_q;
    logic [DW-1:0] dsh_q;
    logic [5:0]    q_q;
    logic [2:0]    idx_q;
    logic          busy_q;
    logic [6:0]    duty_pct_q;
    logic          duty_valid_q;
    logic          qbit;

    assign qbit = (rem_q >= dsh_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q        <= '0;
            dsh_q        <= '0;
            q_q          <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            duty_pct_q   <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            duty_valid_q <= 1'b0;
            // A fresh measurement always restarts the divide, dropping any in flight.
            if (meas_valid_q) begin
                rem_q  <= DW'(high_time_q) * DW'(100);
                dsh_q  <= DW'(period_q) << 6;
                q_q    <= '0;
                idx_q  <= 3'd6;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (qbit) rem_q <= rem_q - dsh_q;
                dsh_q <= dsh_q >> 1;
                q_q   <= {q_q[4:0], qbit};
                idx_q <= idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    duty_pct_q   <= {q_q, qbit};
                    duty_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
            end
        end
    end

    assign bus_io.duty_pct   = duty_pct_q;
    assign bus_io.duty_valid = duty_valid_q;
`else
    assign bus_io.duty_pct   = '0;
    assign bus_io.duty_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: bursts of known waveforms, stuck timing, reset, duty sweep.
module tb_pwm_capture;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 1000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mp[$];
    int mh[$];
    int dq[$];

    always @(negedge clk) begin
        if (bus.meas_valid) begin
            mp.push_back(int'(bus.period));
            mh.push_back(int'(bus.high_time));
        end
        if (bus.duty_valid) dq.push_back(int'(bus.duty_pct));
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every drive and sample lands 1ns after a rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        mp.delete();
        mh.delete();
        dq.delete();
    endtask

    // n full periods plus the closing rise, so n reports when starting from IDLE.
    task automatic burst(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            bus.pwm_in = 1'b1;
            cyc(hi);
            bus.pwm_in = 1'b0;
            cyc(lo);
        end
        bus.pwm_in = 1'b1;
        cyc(20);
    endtask

    task automatic settle();
        bus.pwm_in = 1'b0;
        cyc(TIMEOUT + 10);
    endtask

    task automatic expect_reports(input string tag, input int n, input int ep, input int eh,
                                  input int nd);
        check_val({tag, "_count"}, mp.size(), n);
        for (int i = 0; i < n; i++) begin
            if (mp.size() > 0) begin
                check_val({tag, "_period"}, mp.pop_front(), ep);
                check_val({tag, "_high"}, mh.pop_front(), eh);
            end
        end
`ifdef PWM_CAPTURE_DUTY_EN
        check_val({tag, "_duty_count"}, dq.size(), nd);
        while (dq.size() > 0) check_val({tag, "_duty"}, dq.pop_front(), (eh * 100) / ep);
`else
        check_val({tag, "_duty_count"}, dq.size(), nd - nd);
        check_val({tag, "_duty_tied"}, bus.duty_pct, 0);
`endif
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_period"}, bus.period, 0);
        check_val({tag, "_high"}, bus.high_time, 0);
        check_val({tag, "_mvalid"}, bus.meas_valid, 0);
        check_val({tag, "_stuck_hi"}, bus.stuck_high, 0);
        check_val({tag, "_stuck_lo"}, bus.stuck_low, 0);
        check_val({tag, "_duty"}, bus.duty_pct, 0);
        check_val({tag, "_dvalid"}, bus.duty_valid, 0);
    endtask

    int jit[8] = '{3, -2, 0, -3, 1, 2, -1, 3};

    initial begin
        bus.pwm_in = 1'b0;
        cyc(3);
        check_zero("reset");
        reset = 1'b0;
        cyc(2);

        // Quiet line from reset stays in IDLE: no timeout is armed there.
        settle();
        check_val("idle_no_stuck", bus.stuck_low, 0);

        clear_q();
        burst(80, 20, 3);
        expect_reports("p100", 3, 100, 80, 3);

        settle();
        check_val("p100_stuck_lo", bus.stuck_low, 1);
        check_val("p100_hold", bus.period, 100);

        // Each report aborts the previous divide; only the final one completes.
        clear_q();
        burst(1, 1, 10);
        expect_reports("square", 10, 2, 1, 1);

        settle();
        clear_q();
        bus.pwm_in = 1'b1;
        cyc(1002);
        check_val("stuck_hi_early", bus.stuck_high, 0);
        check_val("rise_clears_lo", bus.stuck_low, 0);
        cyc(1);
        check_val("stuck_hi_set", bus.stuck_high, 1);
        check_val("stuck_hi_hold", bus.period, 2);
        cyc(1200 - 1003);
        bus.pwm_in = 1'b0;
        cyc(30);
        check_val("stuck_hi_clear", bus.stuck_high, 0);
        burst(30, 20, 1);
        expect_reports("after_stuck", 1, 50, 30, 1);

        settle();
        clear_q();
        bus.pwm_in = 1'b1;
        cyc(10);
        reset = 1'b1;
        cyc(1);
        bus.pwm_in = 1'b0;
        cyc(2);
        check_zero("mid_rst");
        reset = 1'b0;
        cyc(10);
        burst(25, 25, 1);
        expect_reports("post_rst", 1, 50, 25, 1);

        for (int k = 1; k < 10; k++) begin
            settle();
            clear_q();
            burst(20 * k, 200 - 20 * k, 1);
            expect_reports($sformatf("sweep%0d", k * 10), 1, 200, 20 * k, 1);
        end
        settle();
        check_val("sweep0_stuck_lo", bus.stuck_low, 1);
        check_val("sweep0_stuck_hi", bus.stuck_high, 0);
        clear_q();
        bus.pwm_in = 1'b1;
        cyc(TIMEOUT + 10);
        check_val("sweep100_stuck_hi", bus.stuck_high, 1);
        check_val("sweep100_no_meas", mp.size(), 0);

        settle();
        clear_q();
        for (int i = 0; i < 8; i++) begin
            bus.pwm_in = 1'b1;
            cyc(32);
            bus.pwm_in = 1'b0;
            cyc(32 + jit[i]);
        end
        bus.pwm_in = 1'b1;
        cyc(20);
        check_val("jit_count", mp.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (mp.size() > 0) begin
                check_val($sformatf("jit%0d_period", i), mp.pop_front(), 64 + jit[i]);
                check_val($sformatf("jit%0d_high", i), mh.pop_front(), 32);
            end
`ifdef PWM_CAPTURE_DUTY_EN
            if (dq.size() > 0) check_val($sformatf("jit%0d_duty", i), dq.pop_front(),
                                         3200 / (64 + jit[i]));
            else check_val($sformatf("jit%0d_duty_missing", i), 0, 1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in `clk` cycles, with an optional duty-cycle percentage. It is the receive-side counterpart of the team's PWM generator. Typical use is closed-loop checking of generator output, or decoding externally supplied PWM such as fan tach or servo commands. The input is asynchronous to `clk`. It is synchronised, edge-detected and timed by a three-state tracker with stuck-line detection.

## Interface
Parameters:
- `CNT_W`, 32: width of the period and high-time counters and outputs.
- `TIMEOUT`, 1000: cycles without a qualifying edge before the line is declared stuck. Must satisfy 2 ≤ `TIMEOUT` < 2^`CNT_W`.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pwm_in`  in  1  PWM input, asynchronous to `clk`.
- `period`  out  `CNT_W`  cycles between the last two rising edges.
- `high_time`  out  `CNT_W`  cycles from the last completed rising edge to the following falling edge.
- `meas_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `stuck_high`  out  1  line held high for ≥ `TIMEOUT` cycles; level output.
- `stuck_low`  out  1  line held low for ≥ `TIMEOUT` cycles; level output.
- `duty_pct`  out  7  floor(100·`high_time`/`period`); only with `PWM_CAPTURE_DUTY_EN`.
- `duty_valid`  out  1  one-cycle pulse when `duty_pct` updates; only with `PWM_CAPTURE_DUTY_EN`.

## Operation
Input conditioning:
- Two-flop synchroniser (`s1`, `s2`) followed by a history flop `s3`.
- `rise = s2 & ~s3`; `fall = ~s2 & s3`.

Counting:
- `cnt` clears to 0 on a `rise` cycle and increments by 1 on every other cycle.
- `cnt` saturates at `TIMEOUT`.

State machine (IDLE, HIGH, LOW):
- IDLE: waits for `rise`, then goes to HIGH. The first pulse after reset or stuck is never reported.
- HIGH: on `fall`, latches `hcnt = cnt + 1` and goes to LOW.
- LOW: on `rise`, loads `period = cnt + 1` and `high_time = hcnt`, pulses `meas_valid`, and goes to HIGH.
- Timeout: in HIGH or LOW, when `cnt == TIMEOUT - 1` and no edge is present, go to IDLE. Set `stuck_high` if `s2 = 1`, otherwise `stuck_low`.
- Any `rise` or `fall` clears both stuck flags.
- `period` and `high_time` hold their last values through stuck conditions and IDLE.
- An edge in the same cycle as the timeout wins: the edge is processed and no timeout occurs.

Reset:
- `period`, `high_time`, `duty_pct`, `meas_valid`, `duty_valid`, `stuck_high`, `stuck_low`, `cnt`, `hcnt`, `s1`, `s2` and `s3` all reset to 0.
- The state machine resets to IDLE.
- Reset mid-measurement discards the partial measurement.

## Timing
- `pwm_in` edge to `rise`/`fall` cycle: 2–3 `clk` cycles.
- `meas_valid` is asserted in the cycle after the `rise` that completes a period; the outputs are valid in that same cycle.
- Minimum measurable phase is 1 cycle high and 1 cycle low after synchronisation. Pulses shorter than one `clk` period may be lost. Lost pulses are not flagged.
- Stuck flags assert `TIMEOUT` cycles after the last edge was detected.

## Configuration
`PWM_CAPTURE_DUTY_EN`:
- Defined: a sequential restoring divider computes `duty_pct`.
  - Starts on `meas_valid` with numerator `high_time·100` and divisor `period`.
  - Produces one quotient bit per cycle for 7 cycles, MSB first.
  - `duty_pct` updates and `duty_valid` pulses 8 cycles after `meas_valid`.
  - A new `meas_valid` during a divide aborts it and restarts with the new values; no `duty_valid` is issued for the aborted divide.
  - Result is at most 100. A period of 0 is impossible by construction.
- Undefined: no divider logic is built; `duty_pct` and `duty_valid` are tied to 0.

## Test plan
- Generator driving `PERIOD = 100` with 80 high: after the second rising edge, `meas_valid` pulses with `period = 100` and `high_time = 80`. With the macro, `duty_valid` follows 8 cycles later with `duty_pct = 80`.
- 1-high/1-low square wave: `period = 2`, `high_time = 1`, `meas_valid` every 2 cycles. With the macro, no `duty_valid` ever fires (divides keep aborting).
- `pwm_in` held high for 1200 cycles with `TIMEOUT = 1000`: `stuck_high` asserts 1000 cycles after the last `rise`; `period` keeps its prior value. A new `rise` clears `stuck_high`; no `meas_valid` until the next full period.
- `reset` pulsed mid-HIGH: all outputs read 0. The first post-reset complete period (e.g. 50 cycles, 25 high) reports `period = 50` and `high_time = 25` exactly once.
- Duty-cycle sweep 0–100 % in 10 % steps on a 200-cycle period:
  - 0 % produces `stuck_low`; 100 % produces `stuck_high`.
  - Intermediate steps report `high_time` = 20·k and `duty_pct` = 10·k.
- Random period jitter of ±3 cycles on a 64-cycle nominal period: every `meas_valid` matches the scoreboard period to the cycle.
